// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT config loader and its cells.
// Truth tables are indexed by {a,b}: bit 3 is a=1,b=1, bit 0 is a=0,b=0.
package lut_cfg_pkg;

    localparam int unsigned CFG_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        COMMIT
    } state_t;

    localparam logic [CFG_W-1:0] AND  = 4'b1000;
    localparam logic [CFG_W-1:0] OR   = 4'b1110;
    localparam logic [CFG_W-1:0] XOR  = 4'b0110;
    localparam logic [CFG_W-1:0] NOR  = 4'b0001;
    localparam logic [CFG_W-1:0] NAND = 4'b0111;

endpackage

// File: rtl/lut_cfg_loader_cell.sv
// One two-input LUT cell: active truth-table register plus a registered 4:1 mux.
// The mux reads the pre-load table, so a load takes effect on the following cycle.
module lut2_cell
    import lut_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CFG_W-1:0] cfg,
    input  logic             a,
    input  logic             b,
    output logic             y
);

    logic [CFG_W-1:0] table_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= '0;
            y       <= 1'b0;
        end else begin
            if (load) begin
                table_q <= cfg;
            end
            y <= table_q[{a, b}];
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Streams per-cell truth tables into a shadow bank and commits them atomically
// to a bank of lut2_cell instances that evaluate continuously.
module lut_cfg_loader #(
    parameter int unsigned NUM_CELLS = 8,
    parameter int unsigned CFG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CFG_W-1:0]     cfg_data,
    input  logic                 cfg_last,
    input  logic                 commit,
    output logic                 busy,
    output logic                 cfg_err,
    input  logic [NUM_CELLS-1:0] eval_a,
    input  logic [NUM_CELLS-1:0] eval_b,
    output logic [NUM_CELLS-1:0] eval_out,
    output logic                 active_ok
);

    import lut_cfg_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(NUM_CELLS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CELLS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CFG_W-1:0] shadow_q [NUM_CELLS];
    logic             err_q;
    logic             ok_q;
    logic             accept;
    logic             commit_load;

    assign accept    = cfg_valid && cfg_ready;
    assign cfg_err   = err_q;
    assign active_ok = ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !cfg_last) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = cfg_last ? DONE : IDLE;
                    end else if (cfg_last) begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (commit) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted, even though the state is IDLE.
    always_comb begin
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        commit_load = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: cfg_ready = 1'b1;
                LOAD: begin
                    cfg_ready = 1'b1;
                    busy      = 1'b1;
                end
                COMMIT: begin
                    busy        = 1'b1;
                    commit_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            ok_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (accept && state_q == IDLE) begin
                shadow_q[0] <= cfg_data;
                cnt_q       <= CNT_W'(1);
                err_q       <= cfg_last;
            end else if (accept && state_q == LOAD) begin
                // Overrun is caught on the final slot before any write beyond it.
                if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    if (cfg_last) begin
                        shadow_q[cnt_q] <= cfg_data;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else begin
                    shadow_q[cnt_q] <= cfg_data;
                    if (cfg_last) begin
                        err_q <= 1'b1;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
            if (state_q == COMMIT) begin
                ok_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        lut2_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (commit_load),
            .cfg   (shadow_q[i]),
            .a     (eval_a[i]),
            .b     (eval_b[i]),
            .y     (eval_out[i])
        );
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomized self-checking bench for lut_cfg_loader against a sequence-level model.
module tb_lut_cfg_loader;

    import lut_cfg_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [3:0]   cfg_data = '0;
    logic         cfg_last = 1'b0;
    logic         commit = 1'b0;
    logic         busy;
    logic         cfg_err;
    logic [N-1:0] eval_a = '0;
    logic [N-1:0] eval_b = '0;
    logic [N-1:0] eval_out;
    logic         active_ok;

    int checks = 0;
    int failures = 0;

    // Model: words of the sequence in progress, completed bank, committed bank.
    logic [3:0] seq [$];
    logic [3:0] shadow_m [N];
    logic [3:0] active_m [N];
    bit         err_m, ok_m, pending_m;

    lut_cfg_loader #(.NUM_CELLS(N), .CFG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .commit(commit), .busy(busy),
        .cfg_err(cfg_err), .eval_a(eval_a), .eval_b(eval_b), .eval_out(eval_out),
        .active_ok(active_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] expect_eval(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        logic [3:0]   t;
        for (int i = 0; i < N; i++) begin
            t    = active_m[i];
            r[i] = t[2 * int'(a[i]) + int'(b[i])];
        end
        return r;
    endfunction

    function automatic void model_reset();
        seq.delete();
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        err_m = 0; ok_m = 0; pending_m = 0;
    endfunction

    function automatic void model_word(input logic [3:0] d, input bit last);
        seq.push_back(d);
        if (seq.size() == 1) err_m = 0;
        if (last) begin
            if (seq.size() == N) begin
                for (int i = 0; i < N; i++) shadow_m[i] = seq[i];
                pending_m = 1;
            end else begin
                err_m = 1;
            end
            seq.delete();
        end else if (seq.size() == N) begin
            err_m = 1;
            seq.delete();
        end
    endfunction

    task automatic send_word(input logic [3:0] d, input bit last);
        bit acc = 0;
        bit rdy;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        for (int k = 0; k < 20 && !acc; k++) begin
            rdy = cfg_ready;
            @(posedge clk);
            if (rdy) acc = 1;
            else @(negedge clk);
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL handshake: word not accepted, got cfg_ready=%b want 1 within 20 cycles", cfg_ready);
        end else begin
            model_word(d, last);
        end
    endtask

    task automatic idle_valid();
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    task automatic pulse_commit();
        bit was_pending;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0; commit = 1'b1;
        was_pending = pending_m;
        @(posedge clk);
        @(negedge clk);
        commit = 1'b0;
        @(posedge clk);
        if (was_pending) begin
            for (int i = 0; i < N; i++) active_m[i] = shadow_m[i];
            ok_m = 1; pending_m = 0;
        end
    endtask

    task automatic drive_eval(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        eval_a = a; eval_b = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; eval_a = '1; eval_b = '1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready, busy, cfg_err, active_ok, eval_out} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got rdy=%b busy=%b err=%b ok=%b out=%h want all 0",
                     cfg_ready, busy, cfg_err, active_ok, eval_out);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (eval_out !== expect_eval(eval_a, eval_b) || active_ok !== ok_m || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got out=%h ok=%b rdy=%b want out=%h ok=%b rdy=1",
                     eval_out, active_ok, cfg_ready, expect_eval(eval_a, eval_b), ok_m);
        end
    endtask

    task automatic test_xor();
        logic [N-1:0] a, b;
        for (int i = 0; i < N; i++) send_word(XOR, i == N - 1);
        idle_valid();
        checks++;
        if (cfg_ready !== 1'b0 || busy !== 1'b0 || cfg_err !== err_m) begin
            failures++;
            $display("FAIL xor_done: got rdy=%b busy=%b err=%b want rdy=0 busy=0 err=%b",
                     cfg_ready, busy, cfg_err, err_m);
        end
        pulse_commit();
        drive_eval(8'hF0, 8'hCC);
        checks++;
        if (eval_out !== expect_eval(8'hF0, 8'hCC) || active_ok !== ok_m) begin
            failures++;
            $display("FAIL xor_eval: got out=%h ok=%b want out=%h ok=%b",
                     eval_out, active_ok, expect_eval(8'hF0, 8'hCC), ok_m);
        end
        for (int r = 0; r < 3; r++) begin
            a = N'($urandom()); b = N'($urandom());
            drive_eval(a, b);
            checks++;
            if (eval_out !== expect_eval(a, b)) begin
                failures++;
                $display("FAIL xor_rand: a=%h b=%h got %h want %h", a, b, eval_out, expect_eval(a, b));
            end
        end
    endtask

    task automatic test_short_last();
        for (int i = 0; i < 5; i++) send_word(4'($urandom()), i == 4);
        idle_valid();
        checks++;
        if (cfg_err !== err_m || cfg_ready !== 1'b1 || busy !== (seq.size() != 0)) begin
            failures++;
            $display("FAIL short_last: got err=%b rdy=%b busy=%b want err=%b rdy=1 busy=0",
                     cfg_err, cfg_ready, busy, err_m);
        end
        pulse_commit();
        drive_eval(8'hF0, 8'hCC);
        checks++;
        if (eval_out !== expect_eval(8'hF0, 8'hCC) || active_ok !== ok_m) begin
            failures++;
            $display("FAIL short_commit_ignored: got out=%h ok=%b want out=%h ok=%b",
                     eval_out, active_ok, expect_eval(8'hF0, 8'hCC), ok_m);
        end
    endtask

    task automatic test_overrun();
        logic [N-1:0] a, b;
        for (int i = 0; i < N; i++) send_word(4'($urandom()), 1'b0);
        idle_valid();
        checks++;
        if (cfg_err !== err_m || busy !== (seq.size() != 0)) begin
            failures++;
            $display("FAIL overrun_err: got err=%b busy=%b want err=%b busy=%b",
                     cfg_err, busy, err_m, seq.size() != 0);
        end
        send_word(4'($urandom()), 1'b0);
        idle_valid();
        checks++;
        if (cfg_err !== err_m || busy !== (seq.size() != 0)) begin
            failures++;
            $display("FAIL overrun_restart: got err=%b busy=%b want err=%b busy=%b",
                     cfg_err, busy, err_m, seq.size() != 0);
        end
        for (int i = 1; i < N; i++) send_word(4'($urandom()), i == N - 1);
        pulse_commit();
        for (int r = 0; r < 3; r++) begin
            a = N'($urandom()); b = N'($urandom());
            drive_eval(a, b);
            checks++;
            if (eval_out !== expect_eval(a, b) || active_ok !== ok_m) begin
                failures++;
                $display("FAIL overrun_eval: a=%h b=%h got %h ok=%b want %h ok=%b",
                         a, b, eval_out, active_ok, expect_eval(a, b), ok_m);
            end
        end
    endtask

    task automatic test_gaps();
        int gap;
        for (int i = 0; i < N; i++) begin
            send_word(AND, i == N - 1);
            gap = $urandom_range(0, 3);
            if (i == 3) begin
                pulse_commit();
            end else if (gap > 0 && i != N - 1) begin
                idle_valid();
                repeat (gap - 1) @(negedge clk);
            end
        end
        idle_valid();
        checks++;
        if (cfg_ready !== !pending_m || cfg_err !== err_m) begin
            failures++;
            $display("FAIL gaps_done: got rdy=%b err=%b want rdy=%b err=%b",
                     cfg_ready, cfg_err, !pending_m, err_m);
        end
        pulse_commit();
        drive_eval(8'hF0, 8'hCC);
        checks++;
        if (eval_out !== expect_eval(8'hF0, 8'hCC)) begin
            failures++;
            $display("FAIL gaps_and_eval: got %h want %h", eval_out, expect_eval(8'hF0, 8'hCC));
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] a, b;
        eval_a = '1; eval_b = '1;
        for (int i = 0; i < 4; i++) send_word(4'($urandom()), 1'b0);
        #2;
        rst_n = 1'b0; cfg_valid = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({cfg_ready, busy, cfg_err, active_ok, eval_out} !== '0) begin
            failures++;
            $display("FAIL async_reset: got rdy=%b busy=%b err=%b ok=%b out=%h want all 0",
                     cfg_ready, busy, cfg_err, active_ok, eval_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) send_word(4'($urandom()), i == N - 1);
        pulse_commit();
        for (int r = 0; r < 3; r++) begin
            a = N'($urandom()); b = N'($urandom());
            drive_eval(a, b);
            checks++;
            if (eval_out !== expect_eval(a, b) || active_ok !== ok_m) begin
                failures++;
                $display("FAIL post_reset_eval: a=%h b=%h got %h ok=%b want %h ok=%b",
                         a, b, eval_out, active_ok, expect_eval(a, b), ok_m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) send_word(4'($urandom()), i == N - 1);
            pulse_commit();
            a = N'($urandom()); b = N'($urandom());
            drive_eval(a, b);
            checks++;
            if (eval_out !== expect_eval(a, b) || active_ok !== ok_m || busy !== 1'b0) begin
                failures++;
                $display("FAIL back_to_back[%0d]: a=%h b=%h got %h ok=%b busy=%b want %h ok=%b busy=0",
                         k, a, b, eval_out, active_ok, busy, expect_eval(a, b), ok_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_short_last();
        test_overrun();
        test_gaps();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
